// File: rtl/fetch_ifid_ctrl_pkg.sv
// Shared definitions for the WISC-F18 fetch stage, reused by the hazard unit
// and the ID stage.
//   PC_W        : program counter / instruction width
//   NOP_INSTR   : encoding inserted into IF/ID on flush or bubble
//   HLT_OPCODE  : opcode (instr[15:12]) that freezes fetch
//   fetch_state_t : FETCH / HALT state encoding
package fetch_ifid_ctrl_pkg;

    localparam int unsigned PC_W       = 16;
    localparam logic [15:0] NOP_INSTR  = 16'h0000;
    localparam logic [3:0]  HLT_OPCODE = 4'b1111;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_ifid_ctrl_if.sv
// Instruction-memory fetch handshake.
//   imem_req   : fetch request (fetch side -> memory)
//   imem_addr  : fetch address (fetch side -> memory)
//   imem_data  : instruction word (memory -> fetch side)
//   imem_ready : imem_data valid for imem_addr this cycle (memory -> fetch side)
// master = fetch stage, slave = instruction memory.
interface fetch_ifid_ctrl_if
    import fetch_ifid_ctrl_pkg::*;
;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [PC_W-1:0] imem_data;
    logic            imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_data,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_data,
        output imem_ready
    );
endinterface

// File: rtl/fetch_ifid_ctrl_ifid_reg.sv
// IF/ID pipeline register with flush, load, bubble and hold.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : clear to NOP / invalid (highest priority after rst)
//   load          : capture instr_in / pc_plus2_in as a valid instruction
//   bubble        : insert NOP / invalid
//   (none of the above) : hold contents
//   instr, pc_plus2, valid : registered outputs to ID
module fetch_ifid_ctrl_ifid_reg
    import fetch_ifid_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] NOP_INSTR = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            load,
    input  logic            bubble,
    input  logic [PC_W-1:0] instr_in,
    input  logic [PC_W-1:0] pc_plus2_in,
    output logic [PC_W-1:0] instr,
    output logic [PC_W-1:0] pc_plus2,
    output logic            valid
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr    <= NOP_INSTR;
            pc_plus2 <= '0;
            valid    <= 1'b0;
        end else if (load) begin
            instr    <= instr_in;
            pc_plus2 <= pc_plus2_in;
            valid    <= 1'b1;
        end else if (bubble) begin
            instr    <= NOP_INSTR;
            pc_plus2 <= '0;
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ifid_ctrl.sv
// Fetch control: owns the PC, the instruction-memory handshake and the IF/ID
// register; applies hazard-unit write enables, branch redirect/flush and HLT.
//   clk, rst        : clock, synchronous active-high reset
//   PC_write_en     : 0 = hold PC
//   IFID_write_en   : 0 = hold IF/ID
//   branch_taken    : redirect to branch_target and flush IF/ID
//   branch_target   : redirect address
//   imem            : fetch handshake (master side)
//   IFID_instr, IFID_pc_plus2, IFID_valid : IF/ID contents to ID
//   halted          : HLT fetched, fetch frozen
module fetch_ifid_ctrl
    import fetch_ifid_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 16'h0000,
    parameter logic [PC_W-1:0] NOP_INSTR  = 16'h0000,
    parameter logic [3:0]      HLT_OPCODE = 4'b1111
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                PC_write_en,
    input  logic                IFID_write_en,
    input  logic                branch_taken,
    input  logic [PC_W-1:0]     branch_target,
    fetch_ifid_ctrl_if.master   imem,
    output logic [PC_W-1:0]     IFID_instr,
    output logic [PC_W-1:0]     IFID_pc_plus2,
    output logic                IFID_valid,
    output logic                halted
);

    fetch_state_t    state, state_next;
    logic [PC_W-1:0] pc, pc_next, pc_plus2;
    logic            is_hlt, accept, ifid_load, ifid_bubble;

    assign pc_plus2       = pc + 16'd2;
    assign imem.imem_addr = pc;
    assign is_hlt         = (imem.imem_data[15:12] == HLT_OPCODE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // A fetch is accepted only when memory is ready and both enables are set;
    // the PC advances only on acceptance, so a word dropped because IF/ID is
    // held is simply refetched from the same PC. An IF/ID write without an
    // accepted word loads a bubble rather than a duplicate.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        accept        = 1'b0;
        ifid_load     = 1'b0;
        ifid_bubble   = 1'b0;
        imem.imem_req = 1'b0;
        halted        = 1'b0;

        case (state)
            FETCH: begin
                imem.imem_req = 1'b1;
                accept        = imem.imem_ready & PC_write_en & IFID_write_en;
                ifid_load     = accept;
                ifid_bubble   = IFID_write_en & ~accept;
                if (accept) begin
                    if (is_hlt) begin
                        state_next = HALT;
                    end else begin
                        pc_next = pc_plus2;
                    end
                end
            end
            HALT: begin
                halted      = 1'b1;
                ifid_bubble = IFID_write_en;
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        // Redirect wins over stall, wait and HALT; also cancels a wrong-path HLT.
        if (branch_taken) begin
            state_next = FETCH;
            pc_next    = branch_target;
        end
    end

    fetch_ifid_ctrl_ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk         (clk),
        .rst         (rst),
        .flush       (branch_taken),
        .load        (ifid_load),
        .bubble      (ifid_bubble),
        .instr_in    (imem.imem_data),
        .pc_plus2_in (pc_plus2),
        .instr       (IFID_instr),
        .pc_plus2    (IFID_pc_plus2),
        .valid       (IFID_valid)
    );

endmodule
